// File: rtl/alu_microsequencer.sv
// Hard-wired control sequencer for one three-register ALU instruction per start.
// Every strobe is registered from the next state, so outputs are glitch-free for the whole state.
module alu_microsequencer #(
  parameter int NREGS       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  localparam int B_PCOUT = 0, B_MARIN = 1, B_INCPC = 2, B_ZIN = 3, B_ZLOW = 4;
  localparam int B_ZHIGH = 5, B_PCIN = 6, B_READ = 7, B_MDRIN = 8, B_MDROUT = 9;
  localparam int B_IRIN = 10, B_YIN = 11, B_HIIN = 12, B_LOIN = 13;

  localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
  localparam logic [4:0]       NREGS_W = 5'(NREGS);
  localparam logic [NREGS-1:0] ONE     = NREGS'(1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [4:0]       opc_q, opc_d;
  logic [3:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [13:0]      strb_q, strb_d;
  logic [NREGS-1:0] rin_q, rin_d, rout_q, rout_d;
  logic [3:0]       alu_q, alu_d;
  logic             busy_q, done_q, done_d, err_q, err_d;
  logic [4:0]       dec_q;
  logic             unused_ir;

  // Returns {legal, alu_code}.
  function automatic logic [4:0] alu_decode(input logic [4:0] opc);
    case (opc)
      5'b00011: alu_decode = {1'b1, 4'd0};
      5'b00100: alu_decode = {1'b1, 4'd1};
      5'b00101: alu_decode = {1'b1, 4'd2};
      5'b00110: alu_decode = {1'b1, 4'd3};
      5'b00111: alu_decode = {1'b1, 4'd4};
      5'b01000: alu_decode = {1'b1, 4'd5};
      5'b01001: alu_decode = {1'b1, 4'd6};
      5'b01010: alu_decode = {1'b1, 4'd7};
      5'b01111: alu_decode = {1'b1, 4'd8};
      5'b10000: alu_decode = {1'b1, 4'd9};
      default:  alu_decode = 5'd0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [4:0] opc);
    is_muldiv = (opc == 5'b01111) || (opc == 5'b10000);
  endfunction

  function automatic logic out_of_range(input logic [3:0] idx);
    out_of_range = ({1'b0, idx} >= NREGS_W);
  endfunction

  // MUL/DIV write HI/LO instead of a general register, so ra is not checked for them.
  function automatic logic instr_bad(input logic [4:0] opc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    logic [4:0] d;
    d = alu_decode(opc);
    instr_bad = !d[4] || out_of_range(rb) || out_of_range(rc) ||
                (!is_muldiv(opc) && out_of_range(ra));
  endfunction

  assign dec_q     = alu_decode(opc_q);
  assign unused_ir = ^ir[14:0];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    strb_d  = '0;
    rin_d   = '0;
    rout_d  = '0;
    alu_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wcnt_d  = '0;
      end
      S_T1: begin
        // Reaching the limit commits the abort; the limit cycle always exits to IDLE.
        if (wcnt_q >= TMO)  state_d = S_IDLE;
        else if (mem_ready) state_d = S_T2;
        else                wcnt_d  = wcnt_q + 8'd1;
      end
      S_T2: begin
        state_d = S_T3;
        opc_d   = ir[31:27];
        ra_d    = ir[26:23];
        rb_d    = ir[22:19];
        rc_d    = ir[18:15];
      end
      S_T3: state_d = instr_bad(opc_q, ra_q, rb_q, rc_q) ? S_IDLE : S_T4;
      S_T4: state_d = S_T5;
      S_T5: state_d = is_muldiv(opc_q) ? S_T6 : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_T0: begin
        strb_d[B_PCOUT] = 1'b1;
        strb_d[B_MARIN] = 1'b1;
        strb_d[B_INCPC] = 1'b1;
        strb_d[B_ZIN]   = 1'b1;
      end
      S_T1: begin
        strb_d[B_READ]  = 1'b1;
        strb_d[B_MDRIN] = 1'b1;
        if (state_q == S_T0) begin
          strb_d[B_ZLOW] = 1'b1;
          strb_d[B_PCIN] = 1'b1;
        end
        if (wcnt_d == TMO) err_d = 1'b1;
      end
      S_T2: begin
        strb_d[B_MDROUT] = 1'b1;
        strb_d[B_IRIN]   = 1'b1;
      end
      S_T3: begin
        if (instr_bad(opc_d, ra_d, rb_d, rc_d)) begin
          err_d = 1'b1;
        end else begin
          strb_d[B_YIN] = 1'b1;
          rout_d        = ONE << rb_d;
        end
      end
      S_T4: begin
        strb_d[B_ZIN] = 1'b1;
        rout_d        = ONE << rc_q;
        alu_d         = dec_q[3:0];
      end
      S_T5: begin
        strb_d[B_ZLOW] = 1'b1;
        if (is_muldiv(opc_q)) begin
          strb_d[B_LOIN] = 1'b1;
        end else begin
          rin_d  = ONE << ra_q;
          done_d = 1'b1;
        end
      end
      S_T6: begin
        strb_d[B_ZHIGH] = 1'b1;
        strb_d[B_HIIN]  = 1'b1;
        done_d          = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      opc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      strb_q  <= '0;
      rin_q   <= '0;
      rout_q  <= '0;
      alu_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      strb_q  <= strb_d;
      rin_q   <= rin_d;
      rout_q  <= rout_d;
      alu_q   <= alu_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign PCout    = strb_q[B_PCOUT];
  assign MARin    = strb_q[B_MARIN];
  assign IncPC    = strb_q[B_INCPC];
  assign Zin      = strb_q[B_ZIN];
  assign Zlowout  = strb_q[B_ZLOW];
  assign Zhighout = strb_q[B_ZHIGH];
  assign PCin     = strb_q[B_PCIN];
  assign Read     = strb_q[B_READ];
  assign MDRin    = strb_q[B_MDRIN];
  assign MDRout   = strb_q[B_MDROUT];
  assign IRin     = strb_q[B_IRIN];
  assign Yin      = strb_q[B_YIN];
  assign HIin     = strb_q[B_HIIN];
  assign LOin     = strb_q[B_LOIN];
  assign Rin      = rin_q;
  assign Rout     = rout_q;
  assign alu_op   = alu_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
